cevero_nmr_ftm: RTL and testbench

- Parametrised fault-tolerance manager for N-modular lockstep ibex cores: NUM_CORES=2 gives DMR detect-and-rollback; NUM_CORES=3 gives TMR majority vote with faulty-core identification.
- Compares per-cycle register-file write streams and committed PCs across cores.
- Keeps a shadow register file plus a checkpoint PC built from agreed writes.
- Sequences recovery (debug request, restore via data port, core reset) and escalates to a sticky fatal error after repeated failed recoveries.

---
 rtl/cevero_ftm_pkg.sv | 25 ++
 rtl/cevero_ftm_voter.sv | 49 ++++
 rtl/cevero_nmr_ftm.sv | 208 ++++++++++++++++++++
 tb/tb_cevero_nmr_ftm.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cevero_ftm_pkg.sv
// Shared types and constants for the N-modular lockstep fault-tolerance manager.
// Tuple fields are 32 bits wide; narrower DATA_W/ADDR_W values are zero-extended into them.
package cevero_ftm_pkg;

  typedef enum logic [2:0] {
    RUN,
    REQ,
    RECOVERING,
    RESET,
    FATAL
  } ftm_state_e;

  localparam int REG_WORDS  = 32;
  localparam int PC_WORD    = 32;
  localparam int TUPLE_XLEN = 32;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [4:0]            waddr;
    logic [TUPLE_XLEN-1:0] wdata;
    logic [TUPLE_XLEN-1:0] pc;
  } ftm_tuple_t;

endpackage

// File: rtl/cevero_ftm_voter.sv
// Combinational compare of per-core tuples: DMR equality or TMR majority vote.
// Identifies the single outvoted core when exactly one of three disagrees.
module cevero_ftm_voter
  import cevero_ftm_pkg::*;
#(
  parameter int NUM_CORES = 2
) (
  input  ftm_tuple_t [NUM_CORES-1:0] tuples_i,
  output logic                       agree_o,
  output logic                       single_fault_o,
  output logic       [NUM_CORES-1:0] faulty_o,
  output ftm_tuple_t                 voted_o
);

  if (NUM_CORES == 3) begin : g_tmr
    logic eq01, eq02, eq12;

    assign eq01 = (tuples_i[0] == tuples_i[1]);
    assign eq02 = (tuples_i[0] == tuples_i[2]);
    assign eq12 = (tuples_i[1] == tuples_i[2]);

    always_comb begin
      agree_o        = eq01 & eq02;
      single_fault_o = 1'b0;
      faulty_o       = '0;
      voted_o        = tuples_i[0];
      if (!agree_o) begin
        if (eq01) begin
          single_fault_o = 1'b1;
          faulty_o[2]    = 1'b1;
        end else if (eq02) begin
          single_fault_o = 1'b1;
          faulty_o[1]    = 1'b1;
        end else if (eq12) begin
          single_fault_o = 1'b1;
          faulty_o[0]    = 1'b1;
          voted_o        = tuples_i[1];
        end
      end
    end
  end else begin : g_dmr
    // Two cores can only detect a disagreement, never attribute it.
    assign agree_o        = (tuples_i[0] == tuples_i[1]);
    assign single_fault_o = 1'b0;
    assign faulty_o       = '0;
    assign voted_o        = tuples_i[0];
  end

endmodule

// File: rtl/cevero_nmr_ftm.sv
// Fault-tolerance manager for lockstep cores: commits agreed writes to a shadow
// regfile, sequences rollback recovery and escalates repeated failures to FATAL.
module cevero_nmr_ftm
  import cevero_ftm_pkg::*;
#(
  parameter int NUM_CORES    = 2,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int RESET_CYCLES = 4,
  parameter int RETRY_WINDOW = 64,
  parameter int MAX_RETRIES  = 3
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             enable_i,
  input  logic [NUM_CORES-1:0]             we_i,
  input  logic [NUM_CORES*5-1:0]           waddr_i,
  input  logic [NUM_CORES*DATA_W-1:0]      wdata_i,
  input  logic [NUM_CORES*ADDR_W-1:0]      pc_i,
  input  logic [NUM_CORES-1:0]             valid_i,
  input  logic                             done_i,
  input  logic                             data_req_i,
  input  logic                             data_we_i,
  input  logic [3:0]                       data_be_i,
  input  logic [31:0]                      data_addr_i,
  output logic                             data_gnt_o,
  output logic                             data_rvalid_o,
  output logic [31:0]                      data_rdata_o,
  output logic                             data_err_o,
  output logic                             recover_o,
  output logic                             reset_o,
  output logic                             recovering_o,
  output logic                             error_o,
  output logic                             correctable_o,
  output logic [NUM_CORES-1:0]             faulty_core_o,
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt_o
);

  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam int WW = $clog2(RETRY_WINDOW + 1);
  localparam int CW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  ftm_state_e                 state_q, state_d;
  ftm_tuple_t [NUM_CORES-1:0] tuples;
  ftm_tuple_t                 voted;
  logic                       agree, single_fault;
  logic       [NUM_CORES-1:0] faulty;
  logic                       cmp_en, mismatch, commit;

  logic [DATA_W-1:0]    shadow_q [REG_WORDS];
  logic [ADDR_W-1:0]    ckpt_pc_q;
  logic [RW-1:0]        retry_q, retry_d, retry_inc;
  logic [WW-1:0]        win_q, win_d;
  logic [CW-1:0]        rst_cnt_q;
  logic                 correctable_q;
  logic [NUM_CORES-1:0] faulty_q;

  logic [5:0]  word;
  logic [31:0] rd_data;
  logic        rd_err;
  logic        rvalid_q, rerr_q;
  logic [31:0] rdata_q;
  logic        unused_ok;

  // Unused fields are zeroed so stale addresses/data never cause false mismatches.
  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_tuple
    assign tuples[gi] = '{
      valid: valid_i[gi],
      we:    we_i[gi],
      waddr: we_i[gi] ? waddr_i[5*gi +: 5] : 5'd0,
      wdata: we_i[gi] ? TUPLE_XLEN'(wdata_i[DATA_W*gi +: DATA_W]) : '0,
      pc:    valid_i[gi] ? TUPLE_XLEN'(pc_i[ADDR_W*gi +: ADDR_W]) : '0
    };
  end

  cevero_ftm_voter #(
    .NUM_CORES(NUM_CORES)
  ) u_voter (
    .tuples_i      (tuples),
    .agree_o       (agree),
    .single_fault_o(single_fault),
    .faulty_o      (faulty),
    .voted_o       (voted)
  );

  assign cmp_en    = (state_q == RUN) && enable_i;
  assign mismatch  = cmp_en && !agree;
  assign commit    = cmp_en && (agree || single_fault);
  assign retry_inc = (retry_q == RW'(MAX_RETRIES)) ? retry_q : retry_q + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (mismatch) begin
          state_d = (win_q != '0 && retry_inc == RW'(MAX_RETRIES)) ? FATAL : REQ;
        end
      end
      REQ:        state_d = RECOVERING;
      RECOVERING: if (done_i) state_d = RESET;
      RESET:      if (rst_cnt_q == CW'(RESET_CYCLES - 1)) state_d = RUN;
      FATAL:      state_d = FATAL;
      default:    state_d = RUN;
    endcase
  end

  always_comb begin
    recover_o    = 1'b0;
    recovering_o = 1'b0;
    reset_o      = 1'b0;
    error_o      = 1'b0;
    unique case (state_q)
      REQ:        recover_o    = 1'b1;
      RECOVERING: recovering_o = 1'b1;
      RESET:      reset_o      = 1'b1;
      FATAL:      error_o      = 1'b1;
      default:    ;
    endcase
  end

  // A mismatch freezes the window; it is reloaded when the core leaves reset.
  always_comb begin
    retry_d = retry_q;
    win_d   = win_q;
    if (state_q == RUN) begin
      if (mismatch) begin
        if (win_q != '0) retry_d = retry_inc;
      end else if (win_q != '0) begin
        win_d = win_q - 1'b1;
        if (win_q == WW'(1)) retry_d = '0;
      end
    end else if (state_q == RESET && state_d == RUN) begin
      win_d = WW'(RETRY_WINDOW);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      retry_q       <= '0;
      win_q         <= '0;
      rst_cnt_q     <= '0;
      correctable_q <= 1'b0;
      faulty_q      <= '0;
    end else begin
      retry_q       <= retry_d;
      win_q         <= win_d;
      rst_cnt_q     <= (state_q == RESET) ? rst_cnt_q + 1'b1 : '0;
      correctable_q <= cmp_en && single_fault;
      if (cmp_en && single_fault) faulty_q <= faulty;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < REG_WORDS; i++) shadow_q[i] <= '0;
      ckpt_pc_q <= '0;
    end else if (commit) begin
      if (voted.we && voted.waddr != 5'd0) shadow_q[voted.waddr] <= voted.wdata[DATA_W-1:0];
      if (voted.valid) ckpt_pc_q <= voted.pc[ADDR_W-1:0];
    end
  end

  assign data_gnt_o = data_req_i & recovering_o;
  assign word       = data_addr_i[7:2];

  always_comb begin
    rd_err  = data_we_i;
    rd_data = '0;
    if (!data_we_i) begin
      if (word < 6'(REG_WORDS)) begin
        rd_data = 32'(shadow_q[word[4:0]]);
      end else if (word == 6'(PC_WORD)) begin
        rd_data = 32'(ckpt_pc_q);
      end else begin
        rd_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= data_gnt_o;
      rerr_q   <= data_gnt_o & rd_err;
      rdata_q  <= data_gnt_o ? rd_data : '0;
    end
  end

  assign data_rvalid_o = rvalid_q;
  assign data_err_o    = rerr_q;
  assign data_rdata_o  = rdata_q;
  assign correctable_o = correctable_q;
  assign faulty_core_o = faulty_q;
  assign retry_cnt_o   = retry_q;
  assign unused_ok     = ^{data_be_i, data_addr_i[31:8], data_addr_i[1:0]};

endmodule

// File: tb/tb_cevero_nmr_ftm.sv
// Directed bench: a DMR and a TMR instance share stimulus; expected values are hand-computed.
module tb_cevero_nmr_ftm;

  logic        clk = 1'b0;
  logic        rst, enable, done;
  logic [2:0]  we, valid;
  logic [14:0] waddr;
  logic [95:0] wdata, pc;
  logic        data_req, data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;

  logic        d_gnt, d_rvalid, d_err, d_recover, d_reset, d_recovering, d_error, d_correctable;
  logic [31:0] d_rdata;
  logic [1:0]  d_faulty, d_retry;
  logic        t_gnt, t_rvalid, t_err, t_recover, t_reset, t_recovering, t_error, t_correctable;
  logic [31:0] t_rdata;
  logic [2:0]  t_faulty;
  logic [1:0]  t_retry;

  logic        g_d, g_t, rv_d, rv_t, er_d, er_t;
  logic [31:0] rd_d, rd_t;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cevero_nmr_ftm #(.NUM_CORES(2)) u_dmr (
    .clk_i(clk), .rst_i(rst), .enable_i(enable),
    .we_i(we[1:0]), .waddr_i(waddr[9:0]), .wdata_i(wdata[63:0]), .pc_i(pc[63:0]), .valid_i(valid[1:0]),
    .done_i(done), .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_gnt_o(d_gnt), .data_rvalid_o(d_rvalid), .data_rdata_o(d_rdata), .data_err_o(d_err),
    .recover_o(d_recover), .reset_o(d_reset), .recovering_o(d_recovering), .error_o(d_error),
    .correctable_o(d_correctable), .faulty_core_o(d_faulty), .retry_cnt_o(d_retry)
  );

  cevero_nmr_ftm #(.NUM_CORES(3)) u_tmr (
    .clk_i(clk), .rst_i(rst), .enable_i(enable),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .pc_i(pc), .valid_i(valid),
    .done_i(done), .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_gnt_o(t_gnt), .data_rvalid_o(t_rvalid), .data_rdata_o(t_rdata), .data_err_o(t_err),
    .recover_o(t_recover), .reset_o(t_reset), .recovering_o(t_recovering), .error_o(t_error),
    .correctable_o(t_correctable), .faulty_core_o(t_faulty), .retry_cnt_o(t_retry)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int k, input logic w, input logic [4:0] a, input logic [31:0] d,
                          input logic [31:0] p, input logic v);
    we[k]            = w;
    waddr[5*k +: 5]  = a;
    wdata[32*k +: 32] = d;
    pc[32*k +: 32]   = p;
    valid[k]         = v;
  endtask

  task automatic idle_cores();
    for (int k = 0; k < 3; k++) set_core(k, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic all_cores(input logic w, input logic [4:0] a, input logic [31:0] d,
                           input logic [31:0] p, input logic v);
    for (int k = 0; k < 3; k++) set_core(k, w, a, d, p, v);
    cyc();
    idle_cores();
  endtask

  // Core 1 flips bit 0 of its write data for one cycle.
  task automatic inject_mismatch(input logic [4:0] a, input logic [31:0] d);
    set_core(0, 1'b1, a, d, 32'h300, 1'b1);
    set_core(1, 1'b1, a, d ^ 32'h1, 32'h300, 1'b1);
    set_core(2, 1'b1, a, d, 32'h300, 1'b1);
    cyc();
    idle_cores();
    $display("[TB] mismatch injected at x%0d", a);
  endtask

  // From REQ: one cycle to RECOVERING, done pulse, RESET_CYCLES cycles back to RUN.
  task automatic run_recovery();
    cyc();
    done = 1'b1;
    cyc();
    done = 1'b0;
    repeat (4) cyc();
    $display("[TB] recovery sequence completed");
  endtask

  task automatic restore_access(input logic [31:0] addr, input logic wr);
    data_req  = 1'b1;
    data_addr = addr;
    data_we   = wr;
    #1;
    g_d = d_gnt;
    g_t = t_gnt;
    cyc();
    data_req = 1'b0;
    data_we  = 1'b0;
    rv_d = d_rvalid; rd_d = d_rdata; er_d = d_err;
    rv_t = t_rvalid; rd_t = t_rdata; er_t = t_err;
    $display("[TB] %s addr=0x%08h gnt=%b/%b rvalid=%b/%b rdata=0x%08h/0x%08h err=%b/%b",
             wr ? "write" : "read", addr, g_d, g_t, rv_d, rv_t, rd_d, rd_t, er_d, er_t);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; done = 1'b0;
    data_req = 1'b0; data_we = 1'b0; data_be = 4'hF; data_addr = 32'h0;
    idle_cores();
    repeat (2) cyc();
    check_eq("rst_ctrl_dmr", {d_recover, d_recovering, d_reset, d_error, d_correctable}, 32'h0);
    check_eq("rst_ctrl_tmr", {t_recover, t_recovering, t_reset, t_error, t_correctable}, 32'h0);
    check_eq("rst_misc_dmr", {d_gnt, d_rvalid, d_err, d_faulty, d_retry}, 32'h0);
    check_eq("rst_misc_tmr", {t_gnt, t_rvalid, t_err, t_faulty, t_retry}, 32'h0);
    check_eq("rst_rdata", d_rdata | t_rdata, 32'h0);
    rst = 1'b0;
    cyc();

    // Matching writes commit; x0 write without valid leaves checkpoint at 0x80.
    all_cores(1'b1, 5'd5, 32'h1234, 32'h80, 1'b1);
    check_eq("match_no_recover", {d_recover, t_recover}, 32'h0);
    all_cores(1'b1, 5'd0, 32'h5555, 32'h84, 1'b0);
    check_eq("x0_no_recover", {d_recover, t_recover}, 32'h0);
    inject_mismatch(5'd6, 32'hAA);
    check_eq("mm_recover_dmr", d_recover, 32'h1);
    check_eq("mm_correctable_tmr", t_correctable, 32'h1);
    check_eq("mm_faulty_tmr", t_faulty, 32'h2);
    cyc();
    check_eq("req_one_cycle", d_recover, 32'h0);
    check_eq("recovering_dmr", d_recovering, 32'h1);
    check_eq("correctable_pulse", t_correctable, 32'h0);

    restore_access(32'd5 * 4, 1'b0);
    check_eq("rd5_gnt", g_d, 32'h1);
    check_eq("rd5_rvalid", rv_d, 32'h1);
    check_eq("rd5_data", rd_d, 32'h1234);
    check_eq("rd5_err", er_d, 32'h0);
    restore_access(32'd32 * 4, 1'b0);
    check_eq("rd_pc_dmr", rd_d, 32'h80);
    check_eq("rd_pc_tmr", rd_t, 32'h300);
    restore_access(32'd6 * 4, 1'b0);
    check_eq("rd6_dmr_uncommitted", rd_d, 32'h0);
    check_eq("rd6_tmr_majority", rd_t, 32'hAA);
    restore_access(32'd0, 1'b0);
    check_eq("rd_x0", rd_d, 32'h0);
    restore_access(32'd40 * 4, 1'b0);
    check_eq("rd40_err", er_d, 32'h1);
    check_eq("rd40_data", rd_d, 32'h0);
    restore_access(32'd5 * 4, 1'b1);
    check_eq("wr_err", er_d, 32'h1);
    restore_access(32'hABCD_EF00 | (32'd5 * 4), 1'b0);
    check_eq("rd5_upper_bits", rd_d, 32'h1234);
    check_eq("rd5_upper_err", er_d, 32'h0);

    done = 1'b1;
    cyc();
    done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("reset_pulse_%0d", i), d_reset, 32'h1);
      cyc();
    end
    check_eq("reset_end", {d_reset, d_recovering, d_recover}, 32'h0);
    check_eq("retry_first", d_retry, 32'h0);

    // In-window mismatch, then let the window expire.
    inject_mismatch(5'd7, 32'h10);
    check_eq("win_retry_1", d_retry, 32'h1);
    run_recovery();
    repeat (63) cyc();
    check_eq("win_still_open", d_retry, 32'h1);
    cyc();
    check_eq("win_expired", d_retry, 32'h0);

    // Escalation: out-of-window mismatch, then three in-window ones.
    inject_mismatch(5'd7, 32'h20);
    check_eq("esc_retry_0", d_retry, 32'h0);
    run_recovery();
    inject_mismatch(5'd7, 32'h30);
    check_eq("esc_retry_1", d_retry, 32'h1);
    run_recovery();
    inject_mismatch(5'd7, 32'h40);
    check_eq("esc_retry_2", d_retry, 32'h2);
    run_recovery();
    inject_mismatch(5'd7, 32'h50);
    check_eq("fatal_error", d_error, 32'h1);
    check_eq("fatal_retry", d_retry, 32'h3);
    check_eq("fatal_no_recover", d_recover, 32'h0);
    done = 1'b1;
    repeat (3) cyc();
    done = 1'b0;
    restore_access(32'd5 * 4, 1'b0);
    check_eq("fatal_no_gnt", g_d, 32'h0);
    check_eq("fatal_sticky", {d_error, d_recovering, d_reset}, 32'h4);
    rst = 1'b1;
    #1;
    check_eq("fatal_cleared", d_error, 32'h0);
    cyc();
    rst = 1'b0;
    cyc();

    // TMR single-core fault: majority committed, core 2 flagged.
    set_core(0, 1'b1, 5'd7, 32'hBEEF, 32'h100, 1'b1);
    set_core(1, 1'b1, 5'd7, 32'hBEEF, 32'h100, 1'b1);
    set_core(2, 1'b1, 5'd7, 32'hDEAD, 32'h100, 1'b1);
    cyc();
    idle_cores();
    check_eq("tmr_correctable", t_correctable, 32'h1);
    check_eq("tmr_faulty", t_faulty, 32'h4);
    check_eq("tmr_recover", t_recover, 32'h1);
    check_eq("tmr_no_error", t_error, 32'h0);
    check_eq("dmr_agree_no_recover", d_recover, 32'h0);
    cyc();
    check_eq("tmr_correctable_pulse", t_correctable, 32'h0);
    restore_access(32'd7 * 4, 1'b0);
    check_eq("tmr_rd7", rd_t, 32'hBEEF);
    check_eq("run_no_gnt_dmr", g_d, 32'h0);
    restore_access(32'd32 * 4, 1'b0);
    check_eq("tmr_rd_pc", rd_t, 32'h100);
    run_recovery();

    for (int k = 0; k < 3; k++) set_core(k, 1'b1, 5'd8, 32'h10 + k, 32'h104, 1'b1);
    cyc();
    idle_cores();
    check_eq("tmr3_recover", t_recover, 32'h1);
    check_eq("tmr3_no_correctable", t_correctable, 32'h0);
    check_eq("tmr3_faulty_held", t_faulty, 32'h4);
    cyc();
    restore_access(32'd8 * 4, 1'b0);
    check_eq("tmr3_rd8", rd_t, 32'h0);
    run_recovery();

    // Asynchronous reset in the middle of the core-reset pulse.
    all_cores(1'b1, 5'd9, 32'h99, 32'h200, 1'b1);
    inject_mismatch(5'd10, 32'h60);
    cyc();
    done = 1'b1;
    cyc();
    done = 1'b0;
    cyc();
    check_eq("mid_reset_active", d_reset, 32'h1);
    rst = 1'b1;
    #1;
    check_eq("async_rst_ctrl", {d_reset, d_recover, d_recovering, d_error}, 32'h0);
    check_eq("async_rst_tmr", {t_reset, t_recover, t_recovering, t_error, t_faulty}, 32'h0);
    cyc();
    rst = 1'b0;
    inject_mismatch(5'd11, 32'h70);
    check_eq("post_rst_run", d_recover, 32'h1);
    cyc();
    restore_access(32'd9 * 4, 1'b0);
    check_eq("post_rst_shadow", rd_d, 32'h0);
    restore_access(32'd32 * 4, 1'b0);
    check_eq("post_rst_pc", rd_d, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
